esc_ramp_sequencer: RTL
=======================

// Module: esc_ramp_sequencer
// PURPOSE
//   Sequences the motor PWM duty/direction for the BLDC ESC. Takes duty/direction commands
//   from the I2C register file (valid/ready handshake) and ramps the PWM duty toward target.
//   Enforces brake -> dead-time -> reverse on direction change, and trips a latched fault
//   when the encoder stops ticking under drive. Outputs feed the PWM generator.
// PARAMETERS
//   DUTY_W    8      duty width, bits
//   STEP_DIV  256    clocks per ramp step of +/-1 duty LSB (>=2)
//   DEAD_CYC  64     clocks with drive_en=0 between direction changes (>=1)
//   STALL_CYC 65535  clocks without enc_tick (duty>=STALL_MIN) before fault
//   STALL_MIN 32     duty below which stall detection is disabled
// PORTS
//   clk        in   1       system clock
//   rst_n      in   1       reset: synchronous, active-low
//   en         in   1       drive enable (tied to ena at top level)
//   cmd_valid  in   1       command valid
//   cmd_ready  out  1       command ready
//   cmd_duty   in   DUTY_W  target duty
//   cmd_dir    in   1       target direction
//   enc_tick   in   1       1-cycle pulse per encoder edge
//   fault_clr  in   1       clears latched fault
//   duty       out  DUTY_W  duty to PWM generator
//   dir        out  1       bridge direction
//   drive_en   out  1       bridge enable
//   fault      out  1       stall fault latched
//   state      out  3       IDLE=0 RAMP=1 RUN=2 BRAKE=3 DEAD=4 FAULT=5
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge, any state): duty=0 dir=0 drive_en=0 fault=0 state=IDLE,
//     tgt_duty=0 tgt_dir=0, all counters 0. Mid-operation reset takes effect that edge.
//   - cmd_ready = en & state in {IDLE,RAMP,RUN,BRAKE}. Accept = cmd_valid&cmd_ready; loads
//     tgt_duty/tgt_dir at that edge, visible to FSM the following cycle.
//   - Prescaler: counts 0..STEP_DIV-1, cleared on entry to RAMP/BRAKE; step occurs when it
//     wraps, so first step is STEP_DIV cycles after entry. Duty never overshoots target.
//   - IDLE: duty=0 drive_en=0. tgt_dir!=dir -> DEAD; else tgt_duty!=0 -> RAMP.
//   - RAMP: drive_en=1; duty steps toward tgt_duty. tgt_dir!=dir -> BRAKE. duty==tgt_duty:
//     -> RUN if nonzero, -> IDLE if zero.
//   - RUN: drive_en=1. tgt_dir!=dir -> BRAKE; tgt_duty!=duty -> RAMP.
//   - BRAKE: drive_en=1; duty steps down to 0 regardless of tgt_duty; at 0 -> DEAD.
//   - DEAD: drive_en=0 duty=0 for exactly DEAD_CYC cycles; on exit dir<=tgt_dir, -> RAMP
//     (tgt_duty!=0) or IDLE. A command arriving during BRAKE replaces target.
//   - Stall counter: cleared on enc_tick, on duty<STALL_MIN, or outside RAMP/RUN;
//     saturating. Reaching STALL_CYC in RAMP/RUN -> FAULT next edge.
//   - FAULT: duty=0 drive_en=0 fault=1, cmd_ready=0; stays until fault_clr=1 -> IDLE,
//     fault=0, tgt_duty=0 (dir kept).
//   - en=0 (not FAULT): next edge duty=0 drive_en=0 state=IDLE tgt_duty=0; held while en=0.
//   - Priority same cycle: rst_n > fault_clr (in FAULT) > stall trip > en=0 > step > cmd.
//     Command accepted on stall-trip cycle is discarded. Step uses pre-accept target.
//   - enc_tick and stall trip same cycle: tick wins (counter clears, no fault).
// TESTING (STEP_DIV=4, DEAD_CYC=8, STALL_CYC=100, STALL_MIN=4)
//   1. Reset, en=1, cmd duty=10 dir=0 -> duty +1 every 4 clk, =10 after 40 clk, state=RUN.
//   2. RUN duty=10 dir=0, cmd duty=5 dir=1 -> BRAKE to 0 in 40 clk, drive_en=0 for 8 clk,
//      dir=1, ramp to 5 in 20 clk, RUN.
//   3. Ramp up to 20, at duty=8 cmd duty=4 -> duty descends to 4, RUN; no overshoot.
//   4. RUN duty=10, no enc_tick 100 clk -> FAULT, fault=1 duty=0; cmds refused;
//      fault_clr -> IDLE fault=0. Periodic enc_tick every 50 clk -> never faults.
//   5. en=0 mid-ramp -> next clk duty=0 drive_en=0 IDLE cmd_ready=0; en=1 stays IDLE.
//   6. rst_n=0 one cycle mid-BRAKE -> all outputs reset values at that edge, state=IDLE.

Source files
------------

// File: rtl/esc_ramp_sequencer_if.sv
// Command channel from the I2C register file: target duty and direction under valid/ready.
interface esc_ramp_sequencer_if #(
    parameter int unsigned DUTY_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_duty;
    logic              cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_duty,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_duty,
        input  cmd_dir,
        output cmd_ready
    );
endinterface

// File: rtl/esc_ramp_sequencer.sv
// BLDC ESC duty/direction sequencer: ramps PWM duty toward the commanded target, reverses
// through brake and dead-time, and latches a fault when the encoder stalls under drive.
module esc_ramp_sequencer #(
    parameter int unsigned DUTY_W    = 8,
    parameter int unsigned STEP_DIV  = 256,
    parameter int unsigned DEAD_CYC  = 64,
    parameter int unsigned STALL_CYC = 65535,
    parameter int unsigned STALL_MIN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    esc_ramp_sequencer_if.slave  cmd,
    input  logic                 enc_tick,
    input  logic                 fault_clr,
    output logic [DUTY_W-1:0]    duty,
    output logic                 dir,
    output logic                 drive_en,
    output logic                 fault,
    output logic [2:0]           state
);

    localparam int unsigned PRE_W   = $clog2(STEP_DIV);
    localparam int unsigned DEAD_W  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_RUN   = 3'd2,
        S_BRAKE = 3'd3,
        S_DEAD  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t              st, st_nx;
    logic [DUTY_W-1:0]   duty_nx;
    logic                dir_nx;
    logic                drive_en_nx;
    logic                fault_nx;
    logic [DUTY_W-1:0]   tgt_duty, tgt_duty_nx;
    logic                tgt_dir, tgt_dir_nx;
    logic [PRE_W-1:0]    pre_cnt, pre_cnt_nx;
    logic [DEAD_W-1:0]   dead_cnt, dead_cnt_nx;
    logic [STALL_W-1:0]  stall_cnt, stall_cnt_nx;

    logic step;
    logic live;
    logic trip;
    logic accept;

    assign state         = st;
    assign cmd.cmd_ready = en && (st == S_IDLE || st == S_RAMP || st == S_RUN || st == S_BRAKE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign step          = (pre_cnt == PRE_W'(STEP_DIV - 1));
    assign live          = (st == S_RAMP) || (st == S_RUN);
    // A tick in the same cycle rescues the motor from tripping.
    assign trip          = live && (stall_cnt >= STALL_W'(STALL_CYC)) && !enc_tick;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            duty      <= '0;
            dir       <= 1'b0;
            drive_en  <= 1'b0;
            fault     <= 1'b0;
            tgt_duty  <= '0;
            tgt_dir   <= 1'b0;
            pre_cnt   <= '0;
            dead_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            st        <= st_nx;
            duty      <= duty_nx;
            dir       <= dir_nx;
            drive_en  <= drive_en_nx;
            fault     <= fault_nx;
            tgt_duty  <= tgt_duty_nx;
            tgt_dir   <= tgt_dir_nx;
            pre_cnt   <= pre_cnt_nx;
            dead_cnt  <= dead_cnt_nx;
            stall_cnt <= stall_cnt_nx;
        end
    end

    // Next-state and datapath; FSM decisions see the pre-accept target.
    always_comb begin
        st_nx       = st;
        duty_nx     = duty;
        dir_nx      = dir;
        fault_nx    = fault;
        tgt_duty_nx = tgt_duty;
        tgt_dir_nx  = tgt_dir;

        if (accept && !trip) begin
            tgt_duty_nx = cmd.cmd_duty;
            tgt_dir_nx  = cmd.cmd_dir;
        end

        if (st == S_FAULT) begin
            if (fault_clr) begin
                st_nx       = S_IDLE;
                fault_nx    = 1'b0;
                tgt_duty_nx = '0;
            end
        end else if (trip) begin
            st_nx    = S_FAULT;
            fault_nx = 1'b1;
            duty_nx  = '0;
        end else if (!en) begin
            st_nx       = S_IDLE;
            duty_nx     = '0;
            tgt_duty_nx = '0;
        end else begin
            case (st)
                S_IDLE: begin
                    duty_nx = '0;
                    if (tgt_dir != dir) begin
                        st_nx = S_DEAD;
                    end else if (tgt_duty != '0) begin
                        st_nx = S_RAMP;
                    end
                end
                S_RAMP: begin
                    if (tgt_dir != dir) begin
                        st_nx = S_BRAKE;
                    end else if (duty == tgt_duty) begin
                        st_nx = (tgt_duty != '0) ? S_RUN : S_IDLE;
                    end else if (step) begin
                        duty_nx = (duty < tgt_duty) ? duty + DUTY_W'(1) : duty - DUTY_W'(1);
                    end
                end
                S_RUN: begin
                    if (tgt_dir != dir) begin
                        st_nx = S_BRAKE;
                    end else if (tgt_duty != duty) begin
                        st_nx = S_RAMP;
                    end
                end
                S_BRAKE: begin
                    if (duty == '0) begin
                        st_nx = S_DEAD;
                    end else if (step) begin
                        duty_nx = duty - DUTY_W'(1);
                    end
                end
                S_DEAD: begin
                    duty_nx = '0;
                    if (dead_cnt == DEAD_W'(DEAD_CYC - 1)) begin
                        dir_nx = tgt_dir;
                        st_nx  = (tgt_duty != '0) ? S_RAMP : S_IDLE;
                    end
                end
                default: begin
                    st_nx   = S_IDLE;
                    duty_nx = '0;
                end
            endcase
        end

        drive_en_nx = (st_nx == S_RAMP) || (st_nx == S_RUN) || (st_nx == S_BRAKE);
    end

    // Step prescaler restarts on every entry into a stepping state.
    always_comb begin
        pre_cnt_nx = '0;
        if ((st_nx == st) && (st == S_RAMP || st == S_BRAKE)) begin
            pre_cnt_nx = step ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    // Dead-time counter runs only while dead-time persists.
    always_comb begin
        dead_cnt_nx = '0;
        if ((st == S_DEAD) && (st_nx == S_DEAD)) begin
            dead_cnt_nx = dead_cnt + DEAD_W'(1);
        end
    end

    // Stall counter: cycles of drive above the detection floor without an encoder edge.
    always_comb begin
        stall_cnt_nx = '0;
        if (live && !enc_tick && (duty >= DUTY_W'(STALL_MIN))) begin
            stall_cnt_nx = (stall_cnt == '1) ? stall_cnt : stall_cnt + STALL_W'(1);
        end
    end

endmodule
